// File: rtl/mem_access_stage.sv
// Memory access stage: req/ack data port, lane alignment, load extension.
// MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning.
module mem_access_stage #(
  parameter int XLEN     = 64,
  parameter int MAX_WAIT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wstrb,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic            bus_err,
  output logic            misalign_exc
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t          state, state_nxt;
  logic            is_mem;
  logic            accept;
  logic            go;
  logic            ack_hit;
  logic            tmo;
  logic [2:0]      size_mask;
  logic [7:0]      strb_base;
  logic [2:0]      off;
  logic [7:0]      wait_cnt;
  logic [2:0]      r_f3;
  logic [2:0]      r_off;
  logic [4:0]      r_rd;
  logic            r_rw;
  logic            r_load;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ld_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic            misal;
`endif

  // Accept/size decode, stall and next-state logic.
  always_comb begin
    state_nxt = state;
    size_mask = 3'b000;
    strb_base = 8'h00;
    is_mem    = in_mem_read | in_mem_write;
    accept    = (state == IDLE) & in_valid;
    unique case (1'b1)
      (in_funct3[1:0] == 2'b00): begin
        size_mask = 3'b000;
        strb_base = 8'h01;
      end
      (in_funct3[1:0] == 2'b01): begin
        size_mask = 3'b001;
        strb_base = 8'h03;
      end
      (in_funct3[1:0] == 2'b10): begin
        size_mask = 3'b011;
        strb_base = 8'h0F;
      end
      (in_funct3[1:0] == 2'b11): begin
        size_mask = 3'b111;
        strb_base = 8'hFF;
      end
    endcase
    off = in_alu_result[2:0] & ~size_mask;
`ifdef MEM_MISALIGN_TRAP_EN
    misal = |(in_alu_result[2:0] & size_mask);
    go    = accept & is_mem & ~misal;
    stall = (state == BUSY) |
            ((state == IDLE) & in_valid & is_mem & ~misal);
`else
    go    = accept & is_mem;
    stall = (state == BUSY) |
            ((state == IDLE) & in_valid & is_mem);
`endif
    ack_hit = (state == BUSY) & dmem_ack;
    tmo     = (state == BUSY) & ~dmem_ack &
              (wait_cnt == WAIT_LAST);
    unique case (state)
      IDLE: if (go) state_nxt = BUSY;
      BUSY: if (ack_hit | tmo) state_nxt = IDLE;
    endcase
  end

  // Select the addressed lane and extend it by funct3.
  always_comb begin
    lane    = dmem_rdata >> {r_off, 3'b000};
    ld_data = lane;
    unique case (r_f3)
      3'b000:  ld_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b010:  ld_data = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      3'b110:  ld_data = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: ld_data = lane;
    endcase
  end

  // Request, timeout and writeback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_wstrb   <= '0;
      r_f3         <= '0;
      r_off        <= '0;
      r_rd         <= '0;
      r_rw         <= 1'b0;
      r_load       <= 1'b0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      bus_err      <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_exc <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      wb_valid <= 1'b0;
      bus_err  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_exc <= 1'b0;
`endif
      if (accept && !is_mem) begin
        wb_valid     <= 1'b1;
        wb_data      <= in_alu_result;
        wb_rd        <= in_rd;
        wb_reg_write <= in_reg_write;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      if (accept && is_mem && misal) begin
        wb_valid     <= 1'b1;
        wb_data      <= '0;
        wb_rd        <= in_rd;
        wb_reg_write <= 1'b0;
        bus_err      <= 1'b1;
        misalign_exc <= 1'b1;
      end
`endif
      if (go) begin
        dmem_req   <= 1'b1;
        dmem_we    <= ~in_mem_read;
        dmem_addr  <= {in_alu_result[XLEN-1:3], 3'b000};
        dmem_wdata <= in_rs2 << {off, 3'b000};
        dmem_wstrb <= strb_base << off;
        r_f3       <= in_funct3;
        r_off      <= off;
        r_rd       <= in_rd;
        r_rw       <= in_reg_write;
        r_load     <= in_mem_read;
        wait_cnt   <= '0;
      end
      if (ack_hit) begin
        dmem_req     <= 1'b0;
        wb_valid     <= 1'b1;
        wb_rd        <= r_rd;
        wb_data      <= r_load ? ld_data : '0;
        wb_reg_write <= r_load & r_rw;
      end else if (tmo) begin
        dmem_req     <= 1'b0;
        wb_valid     <= 1'b1;
        wb_rd        <= r_rd;
        wb_data      <= '0;
        wb_reg_write <= 1'b0;
        bus_err      <= 1'b1;
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

`ifndef MEM_MISALIGN_TRAP_EN
  assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a transaction-level model.
// Honors MEM_MISALIGN_TRAP_EN when defined for the build.
module tb_mem_access_stage;

  localparam int MAX_WAIT = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [2:0]  in_funct3;
  logic [63:0] in_alu_result;
  logic [63:0] in_rs2;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic [63:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        bus_err;
  logic        misalign_exc;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.XLEN(64), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_funct3(in_funct3),
    .in_alu_result(in_alu_result), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_reg_write(in_reg_write),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .bus_err(bus_err), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 8;
    endcase
  endfunction

  // Architectural load result: pick the naturally aligned element and extend.
  function automatic logic [63:0] ref_load(input logic [63:0] rdata,
                                           input logic [63:0] addr,
                                           input logic [2:0]  f3);
    int          sz;
    int          off;
    logic [63:0] ea;
    logic [63:0] v;
    logic [63:0] m;
    sz  = size_of(f3);
    ea  = addr - (addr % 64'(sz));
    off = int'(ea % 64'd8);
    v   = rdata >> (8 * off);
    if (sz == 8) return v;
    m = (64'd1 << (8 * sz)) - 64'd1;
    v = v & m;
    if (!f3[2] && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  task automatic idle_inputs;
    in_valid      = 1'b0;
    in_mem_read   = 1'b0;
    in_mem_write  = 1'b0;
    in_funct3     = 3'b000;
    in_alu_result = '0;
    in_rs2        = '0;
    in_rd         = '0;
    in_reg_write  = 1'b0;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 read+write (load)
  task automatic run_txn(input int kind, input logic [2:0] f3,
                         input logic [63:0] addr,
                         input logic [63:0] rs2,
                         input logic [4:0] rd, input logic rw,
                         input int ack_delay,
                         input logic [63:0] rdata);
    int          sz, off, n, n_exp, st_cnt, unstable;
    logic [63:0] ea, exp_addr, exp_wdata;
    logic [7:0]  exp_strb;
    logic        mem, ld, mis, to;
    mem = (kind != 0);
    ld  = (kind == 1) || (kind == 3);
    sz  = size_of(f3);
    mis = mem && ((addr % 64'(sz)) != 64'd0);
    ea  = addr - (addr % 64'(sz));
    off = int'(ea % 64'd8);
    exp_addr  = ea - (ea % 64'd8);
    exp_strb  = 8'(((1 << sz) - 1) << off);
    exp_wdata = rs2 << (8 * off);
    in_valid      = 1'b1;
    in_mem_read   = (kind == 1) || (kind == 3);
    in_mem_write  = (kind == 2) || (kind == 3);
    in_funct3     = f3;
    in_alu_result = addr;
    in_rs2        = rs2;
    in_rd         = rd;
    in_reg_write  = rw;
    #1;
    st_cnt = int'(stall);
    tick();
    idle_inputs();
    if (!mem) begin
      chk("alu_wb_valid", 64'(wb_valid), 64'd1);
      chk("alu_wb_data", wb_data, addr);
      chk("alu_wb_rd", 64'(wb_rd), 64'(rd));
      chk("alu_wb_we", 64'(wb_reg_write), 64'(rw));
      chk("alu_stall", 64'(st_cnt + int'(stall)), 64'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    end else if (mis) begin
      chk("mis_wb_valid", 64'(wb_valid), 64'd1);
      chk("mis_exc", 64'(misalign_exc), 64'd1);
      chk("mis_bus_err", 64'(bus_err), 64'd1);
      chk("mis_wb_we", 64'(wb_reg_write), 64'd0);
      chk("mis_no_req", 64'(dmem_req), 64'd0);
      chk("mis_stall", 64'(st_cnt), 64'd0);
`endif
    end else begin
      chk("req_rise", 64'(dmem_req), 64'd1);
      chk("req_addr", dmem_addr, exp_addr);
      chk("req_we", 64'(dmem_we), 64'(!ld));
      if (!ld) begin
        chk("req_wstrb", 64'(dmem_wstrb), 64'(exp_strb));
        chk("req_wdata", dmem_wdata, exp_wdata);
      end
      n = 0;
      unstable = 0;
      while (dmem_req === 1'b1 && n < MAX_WAIT + 4) begin
        st_cnt += int'(stall);
        if (dmem_addr !== exp_addr || dmem_we !== !ld) unstable++;
        if (!ld && (dmem_wstrb !== exp_strb ||
                    dmem_wdata !== exp_wdata)) unstable++;
        if (n == ack_delay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = {$urandom, $urandom};
        n++;
      end
      to    = (ack_delay >= MAX_WAIT);
      n_exp = to ? MAX_WAIT : ack_delay + 1;
      chk("req_stable", 64'(unstable), 64'd0);
      chk("req_cycles", 64'(n), 64'(n_exp));
      chk("stall_cycles", 64'(st_cnt), 64'(n_exp + 1));
      chk("mem_wb_valid", 64'(wb_valid), 64'd1);
      chk("mem_bus_err", 64'(bus_err), 64'(to));
      chk("mem_exc", 64'(misalign_exc), 64'd0);
      chk("mem_wb_rd", 64'(wb_rd), 64'(rd));
      chk("mem_wb_we", 64'(wb_reg_write), 64'(ld && !to && rw));
      chk("mem_wb_data", wb_data,
          (ld && !to) ? ref_load(rdata, addr, f3) : 64'd0);
    end
    tick();
    chk("wb_pulse", 64'(wb_valid), 64'd0);
  endtask

  initial begin
    int          kind;
    logic [2:0]  f3;
    logic [63:0] a;
    int          dly;
    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    idle_inputs();
    tick();
    tick();
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    rst_n = 1'b1;
    tick();

    // async reset while a request is outstanding
    in_valid      = 1'b1;
    in_mem_read   = 1'b1;
    in_funct3     = 3'b011;
    in_alu_result = 64'h40;
    in_rd         = 5'd7;
    in_reg_write  = 1'b1;
    tick();
    idle_inputs();
    chk("busy_req", 64'(dmem_req), 64'd1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", 64'(dmem_req), 64'd0);
    chk("async_stall", 64'(stall), 64'd0);
    chk("async_wb", {wb_data[58:0], wb_rd}, 64'd0);
    chk("async_wbv", 64'({wb_valid, wb_reg_write, bus_err}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_txn(0, 3'b000, 64'h1234, 64'd0, 5'd5, 1'b1, 0, 64'd0);
    run_txn(1, 3'b000, 64'h1003, 64'd0, 5'd9, 1'b1, 1,
            64'h0000_0000_8000_0000);
    run_txn(2, 3'b001, 64'h2006, 64'hABCD, 5'd3, 1'b1, 0, 64'd0);
    run_txn(1, 3'b110, 64'h10, 64'd0, 5'd4, 1'b1, MAX_WAIT, 64'd0);
    run_txn(1, 3'b010, 64'h1002, 64'd0, 5'd6, 1'b1, 0,
            64'h1111_2222_8765_4321);
    run_txn(1, 3'b011, 64'h88, 64'd0, 5'd8, 1'b1, MAX_WAIT - 1,
            64'hDEAD_BEEF_0BAD_F00D);
    run_txn(1, 3'b111, 64'h18, 64'd0, 5'd2, 1'b1, 0,
            64'hFEDC_BA98_7654_3210);

    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 3));
      f3   = 3'($urandom_range(0, 7));
      if (kind == 2) f3[2] = 1'b0;
      a    = {$urandom, $urandom};
      dly  = ($urandom_range(0, 40) == 0) ? MAX_WAIT
                                          : int'($urandom_range(0, 4));
      run_txn(kind, f3, a, {$urandom, $urandom},
              5'($urandom), 1'($urandom), dly, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
